// File: rtl/store_processing_unit_pkg.sv
// Shared definitions for the load/store processing units: FUNC3 codes,
// the store FSM state encoding and the store legality check.
package store_processing_unit_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } spuState_e;

  // True when the store is a known opcode and its address suits its size.
  function automatic logic storeAccepted(logic [2:0] func3, logic [1:0] offset);
    logic ok;
    case (func3)
      F3_SB:   ok = 1'b1;
      F3_SH:   ok = ~offset[0];
      F3_SW:   ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops the store data onto its byte/halfword lane
// of the old memory word, leaving the other lanes untouched.
module store_lane_merge
  import store_processing_unit_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] write_data_i,
  input  logic [31:0] old_word_i,
  output logic [31:0] merged_word_o
);

  // Start from the old word and overwrite only the lane the store targets.
  always_comb begin
    merged_word_o = old_word_i;
    case (func3_i)
      F3_SB: begin
        case (offset_i)
          2'd0: merged_word_o[7:0]   = write_data_i[7:0];
          2'd1: merged_word_o[15:8]  = write_data_i[7:0];
          2'd2: merged_word_o[23:16] = write_data_i[7:0];
          default: merged_word_o[31:24] = write_data_i[7:0];
        endcase
      end
      F3_SH: begin
        if (offset_i[1]) merged_word_o[31:16] = write_data_i[15:0];
        else             merged_word_o[15:0]  = write_data_i[15:0];
      end
      F3_SW:   merged_word_o = write_data_i;
      default: merged_word_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/store_processing_unit.sv
// Store path of the MEM stage: accepts SB/SH/SW, performs read-modify-write
// on a word-only memory, stalls the pipeline until the write lands and
// rejects misaligned or unknown stores with a one-cycle fault pulse.
module store_processing_unit
  import store_processing_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter bit SW_BYPASS  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  store_req_i,
  input  logic [2:0]            func3_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [31:0]           write_data_i,
  output logic                  busywait_o,
  output logic                  store_fault_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-3:0] mem_address_o,
  output logic [31:0]           mem_writedata_o,
  input  logic [31:0]           mem_readdata_i,
  input  logic                  mem_busywait_i
);

  spuState_e             state_q, state_d;
  logic [2:0]            func3_q, func3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           memWdata_q, memWdata_d;
  logic                  fault_q, fault_d;
  logic [31:0]           mergedWord;

  store_lane_merge u_merge (
    .func3_i       (func3_q),
    .offset_i      (addr_q[1:0]),
    .write_data_i  (wdata_q),
    .old_word_i    (mem_readdata_i),
    .merged_word_o (mergedWord)
  );

  // Registered state and the latched store; reset abandons any store in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      func3_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      memWdata_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      func3_q    <= func3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      memWdata_q <= memWdata_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state, latch control and strobe/stall decode from the current state.
  always_comb begin
    state_d     = state_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    memWdata_d  = memWdata_q;
    fault_d     = 1'b0;
    busywait_o  = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (store_req_i) begin
          if (storeAccepted(func3_i, address_i[1:0])) begin
            busywait_o = 1'b1;
            func3_d    = func3_i;
            addr_d     = address_i;
            wdata_d    = write_data_i;
            if (SW_BYPASS && (func3_i == F3_SW)) begin
              memWdata_d = write_data_i;
              state_d    = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        busywait_o = 1'b1;
        mem_read_o = 1'b1;
        if (!mem_busywait_i) begin
          memWdata_d = mergedWord;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        busywait_o  = 1'b1;
        mem_write_o = 1'b1;
        if (!mem_busywait_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign store_fault_o   = fault_q;
  assign mem_address_o   = addr_q[ADDR_WIDTH-1:2];
  assign mem_writedata_o = memWdata_q;

endmodule

// File: tb/tb_store_processing_unit.sv
// Self-checking bench for store_processing_unit: a word memory with
// configurable wait states, a transaction-level reference model checked
// every cycle, and directed stores with hand-computed results.
module tb_store_processing_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        store_req = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic        busywait, store_fault, mem_read, mem_write, mem_busywait;
  logic [29:0] mem_address;
  logic [31:0] mem_writedata, mem_readdata;

  int total = 0;
  int bad = 0;

  store_processing_unit #(.ADDR_WIDTH(32), .SW_BYPASS(1'b1)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .store_req_i     (store_req),
    .func3_i         (func3),
    .address_i       (address),
    .write_data_i    (write_data),
    .busywait_o      (busywait),
    .store_fault_o   (store_fault),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .mem_address_o   (mem_address),
    .mem_writedata_o (mem_writedata),
    .mem_readdata_i  (mem_readdata),
    .mem_busywait_i  (mem_busywait)
  );

  always #5 clk = ~clk;

  // Word memory with per-access wait states
  logic [31:0] memArr [0:4095];
  int waitCfg = 0;
  int waitLeft = 0;

  assign mem_readdata = memArr[mem_address[11:0]];
  assign mem_busywait = (mem_read | mem_write) && (waitLeft != 0);

  // Count down wait states per access and commit completed writes.
  always @(posedge clk) begin
    if ((mem_read | mem_write) && waitLeft != 0) waitLeft <= waitLeft - 1;
    else waitLeft <= waitCfg;
    if (mem_write && !mem_busywait) memArr[mem_address[11:0]] <= mem_writedata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic legalStore(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'd0) return 1'b1;
    if (f3 == 3'd1) return off[0] == 1'b0;
    if (f3 == 3'd2) return off == 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] refMerge(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] data, input logic [31:0] old);
    int sh;
    if (f3 == 3'd0) begin
      sh = 8 * int'(off);
      return (old & ~(32'h0000_00FF << sh)) | ({24'h0, data[7:0]} << sh);
    end
    if (f3 == 3'd1) begin
      sh = off[1] ? 16 : 0;
      return (old & ~(32'h0000_FFFF << sh)) | ({16'h0, data[15:0]} << sh);
    end
    return data;
  endfunction

  // Reference model: one outstanding store, its target word and final value
  logic        active = 1'b0;
  logic        expFault = 1'b0;
  logic [31:0] expAddr = 32'h0;
  logic [31:0] expWord = 32'h0;
  logic        expNoRead = 1'b0;

  // Track acceptance, faults and completion at transaction level.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   = 1'b0;
      expFault = 1'b0;
    end else begin
      expFault = 1'b0;
      if (active) begin
        if (mem_write && !mem_busywait) active = 1'b0;
      end else if (store_req) begin
        if (legalStore(func3, address[1:0])) begin
          active    = 1'b1;
          expAddr   = {2'b00, address[31:2]};
          expWord   = refMerge(func3, address[1:0], write_data, memArr[address[13:2]]);
          expNoRead = (func3 == 3'd2);
        end else begin
          expFault = 1'b1;
        end
      end
    end
  end

  // Compare DUT outputs against the model on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("busywait", {31'h0, busywait},
                  {31'h0, active | (store_req & legalStore(func3, address[1:0]))});
      checkOutput("storeFault", {31'h0, store_fault}, {31'h0, expFault});
      if (!active) begin
        checkOutput("idleStrobes", {30'h0, mem_read, mem_write}, 32'h0);
      end else begin
        checkOutput("oneStrobe", {31'h0, mem_read & mem_write}, 32'h0);
        if (mem_read) begin
          checkOutput("readAddr", {2'b00, mem_address}, expAddr);
          checkOutput("swNoRead", {31'h0, expNoRead}, 32'h0);
        end
        if (mem_write) begin
          checkOutput("writeAddr", {2'b00, mem_address}, expAddr);
          checkOutput("writeData", mem_writedata, expWord);
        end
      end
    end
  end

  int          obsBusy, obsReads, obsWrites;
  logic [31:0] obsWrAddr, obsWrData;

  // Present a store and hold it until the memory write completes.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bit done;
    func3 = f3; address = a; write_data = d; store_req = 1'b1;
    obsBusy = 0; obsReads = 0; obsWrites = 0;
    obsWrAddr = 32'h0; obsWrData = 32'h0;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (n > 0 && busywait) obsBusy++;
      if (mem_read) obsReads++;
      if (mem_write) begin
        obsWrites++;
        obsWrAddr = {2'b00, mem_address};
        obsWrData = mem_writedata;
        if (!mem_busywait) done = 1'b1;
      end
    end
    if (!done) checkOutput("storeTimeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    store_req = 1'b0;
  endtask

  // Present a rejected store for one cycle and check the fault pulse.
  task automatic applyFault(input logic [2:0] f3, input logic [31:0] a);
    func3 = f3; address = a; write_data = 32'hA5A5_A5A5; store_req = 1'b1;
    @(negedge clk);
    checkOutput("faultNoStall", {31'h0, busywait}, 32'h0);
    @(posedge clk); #1;
    store_req = 1'b0;
    @(negedge clk);
    checkOutput("faultPulse", {31'h0, store_fault}, 32'h1);
    checkOutput("faultNoStrobe", {30'h0, mem_read, mem_write}, 32'h0);
    @(negedge clk);
    checkOutput("faultOneCycle", {31'h0, store_fault}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) memArr[i] = 32'h0;
    memArr[12'h400] = 32'h1122_3344;
    memArr[12'h800] = 32'hFFFF_FFFF;
    memArr[12'hC00] = 32'h0000_0000;
    memArr[12'h200] = 32'hCAFE_F00D;
    memArr[12'h004] = 32'h0000_0000;

    #2;
    checkOutput("rstBusy", {31'h0, busywait}, 32'h0);
    checkOutput("rstFault", {31'h0, store_fault}, 32'h0);
    checkOutput("rstStrobes", {30'h0, mem_read, mem_write}, 32'h0);
    checkOutput("rstAddr", {2'b00, mem_address}, 32'h0);
    checkOutput("rstWdata", mem_writedata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] SB to 0x1001, zero wait");
    waitCfg = 0;
    applyStimulus(3'd0, 32'h0000_1001, 32'hFFFF_FFAB);
    checkOutput("sbReads", 32'(obsReads), 32'd1);
    checkOutput("sbWrites", 32'(obsWrites), 32'd1);
    checkOutput("sbBusy", 32'(obsBusy), 32'd2);
    checkOutput("sbAddr", obsWrAddr, 32'h0000_0400);
    checkOutput("sbData", obsWrData, 32'h1122_AB44);
    checkOutput("sbMem", memArr[12'h400], 32'h1122_AB44);

    $display("[TB] SB to top byte 0x1003");
    applyStimulus(3'd0, 32'h0000_1003, 32'h0000_005A);
    checkOutput("sbTopMem", memArr[12'h400], 32'h5A22_AB44);

    $display("[TB] SH to 0x2002, three wait states");
    waitCfg = 3;
    applyStimulus(3'd1, 32'h0000_2002, 32'h0000_BEEF);
    checkOutput("shReads", 32'(obsReads), 32'd4);
    checkOutput("shWrites", 32'(obsWrites), 32'd4);
    checkOutput("shBusy", 32'(obsBusy), 32'd8);
    checkOutput("shData", obsWrData, 32'hBEEF_FFFF);
    checkOutput("shMem", memArr[12'h800], 32'hBEEF_FFFF);

    $display("[TB] SW to 0x3000, bypass read");
    waitCfg = 0;
    applyStimulus(3'd2, 32'h0000_3000, 32'hDEAD_BEEF);
    checkOutput("swReads", 32'(obsReads), 32'd0);
    checkOutput("swWrites", 32'(obsWrites), 32'd1);
    checkOutput("swAddr", obsWrAddr, 32'h0000_0C00);
    checkOutput("swData", obsWrData, 32'hDEAD_BEEF);
    checkOutput("swMem", memArr[12'hC00], 32'hDEAD_BEEF);

    $display("[TB] rejected stores");
    applyFault(3'd2, 32'h0000_3002);
    applyFault(3'd3, 32'h0000_3000);
    applyFault(3'd1, 32'h0000_2001);
    checkOutput("faultMemKept", memArr[12'hC00], 32'hDEAD_BEEF);

    $display("[TB] reset during a stalled write");
    waitCfg = 50;
    func3 = 3'd2; address = 32'h0000_0800; write_data = 32'h1234_5678; store_req = 1'b1;
    for (int n = 0; n < 20 && !mem_write; n++) @(negedge clk);
    checkOutput("rstSawWrite", {31'h0, mem_write}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    store_req = 1'b0;
    #1;
    checkOutput("rstWriteDrop", {31'h0, mem_write}, 32'h0);
    checkOutput("rstReadDrop", {31'h0, mem_read}, 32'h0);
    checkOutput("rstBusyDrop", {31'h0, busywait}, 32'h0);
    @(posedge clk); #1;
    waitCfg = 0;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstIdle", {29'h0, busywait, mem_read, mem_write}, 32'h0);
    checkOutput("postRstMem", memArr[12'h200], 32'hCAFE_F00D);
    @(posedge clk); #1;

    $display("[TB] back-to-back SB on word 4");
    applyStimulus(3'd0, 32'h0000_0010, 32'h0000_0011);
    checkOutput("b2bFirst", memArr[12'h004], 32'h0000_0011);
    applyStimulus(3'd0, 32'h0000_0011, 32'h0000_0022);
    checkOutput("b2bData", obsWrData, 32'h0000_2211);
    checkOutput("b2bMem", memArr[12'h004], 32'h0000_2211);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
